// File: rtl/test_sig_gen_pkg.sv
// Shared types and helpers for the multi-lane AXI4-Stream test-signal generator.
package test_sig_gen_pkg;

  typedef enum logic [1:0] {
    RAMP   = 2'd0,
    SQUARE = 2'd1,
    COUNT  = 2'd2,
    ZERO   = 2'd3
  } mode_t;

  localparam int MAX_W = 64;

  // Bit pattern of the most negative (neg=1) or most positive (neg=0) w-bit signed value.
  function automatic logic [MAX_W-1:0] sample_limit(input int w, input bit neg);
    logic [MAX_W-1:0] msb;
    msb = MAX_W'(1) << (w - 1);
    return neg ? msb : (msb - MAX_W'(1));
  endfunction

  function automatic bit params_ok(input int phase_w, input int sample_w,
                                   input int n_lanes, input int pkt_len);
    return (sample_w >= 1) && (sample_w <= phase_w) && (phase_w <= MAX_W) &&
           (n_lanes >= 1) && (pkt_len >= 1);
  endfunction

endpackage

// File: rtl/test_sig_gen_lane.sv
// One output lane: phase offset for lane LANE plus the waveform mode mux (combinational).
module test_sig_gen_lane
  import test_sig_gen_pkg::*;
#(
  parameter int PHASE_W  = 20,
  parameter int SAMPLE_W = 16,
  parameter int N_LANES  = 8,
  parameter int CNT_W    = 8,
  parameter int LANE     = 0
) (
  input  logic [PHASE_W-1:0]  acc,
  input  logic [PHASE_W-1:0]  poff,
  input  logic [PHASE_W-1:0]  pinc,
  input  mode_t               mode,
  input  logic [CNT_W-1:0]    beat,
  output logic [SAMPLE_W-1:0] sample
);

  localparam logic [MAX_W-1:0] SMAX_L = sample_limit(SAMPLE_W, 1'b0);
  localparam logic [MAX_W-1:0] SMIN_L = sample_limit(SAMPLE_W, 1'b1);
  localparam logic signed [SAMPLE_W-1:0] SMAX = SMAX_L[SAMPLE_W-1:0];
  localparam logic signed [SAMPLE_W-1:0] SMIN = SMIN_L[SAMPLE_W-1:0];

  logic [PHASE_W-1:0]  ph;
  logic [SAMPLE_W-1:0] cnt;

  assign ph  = acc + poff + PHASE_W'(LANE) * pinc;
  assign cnt = SAMPLE_W'(beat) * SAMPLE_W'(N_LANES) + SAMPLE_W'(LANE);

  always_comb begin
    sample = '0;
    case (mode)
      RAMP:   sample = ph[PHASE_W-1 -: SAMPLE_W];
      SQUARE: sample = ph[PHASE_W-1] ? SMIN : SMAX;
      COUNT:  sample = cnt;
      ZERO:   sample = '0;
    endcase
  end

endmodule

// File: rtl/test_sig_gen_mc.sv
// Multi-lane test-signal generator: phase accumulator, staged config, resync and
// tlast packetisation behind a single AXI4-Stream output register.
module test_sig_gen_mc
  import test_sig_gen_pkg::*;
#(
  parameter int PHASE_W  = 20,
  parameter int SAMPLE_W = 16,
  parameter int N_LANES  = 8,
  parameter int PKT_LEN  = 256
) (
  input  logic                         m_axis_aclk,
  input  logic                         m_axis_aresetn,
  input  logic [PHASE_W-1:0]           pinc,
  input  logic [PHASE_W-1:0]           poff,
  input  mode_t                        mode,
  input  logic                         valid_in,
  input  logic                         resync,
  output logic [N_LANES*SAMPLE_W-1:0]  m_axis_tdata,
  output logic                         m_axis_tvalid,
  output logic                         m_axis_tlast,
  input  logic                         m_axis_tready
);

  localparam int CNT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PKT_LEN - 1);

  if (!params_ok(PHASE_W, SAMPLE_W, N_LANES, PKT_LEN)) begin : g_param_check
    $error("test_sig_gen_mc: illegal parameter combination");
  end

  logic [PHASE_W-1:0] pinc_s, poff_s, pinc_a, poff_a, pinc_n, poff_n;
  mode_t              mode_s, mode_a, mode_n;
  logic               cfg_pend;
  logic [PHASE_W-1:0] acc, acc_b;
  logic [CNT_W-1:0]   beat_cnt, beat_b;
  logic               resync_pend, restart, beat_last, load;
  logic [N_LANES*SAMPLE_W-1:0] data_n, data_p0;
  logic               vld_p0, last_p0;

  assign load = !vld_p0 || m_axis_tready;

  // cfg_pend marks a shadow strobed during a stall that active has not yet taken.
  assign pinc_n = valid_in ? pinc : (cfg_pend ? pinc_s : pinc_a);
  assign poff_n = valid_in ? poff : (cfg_pend ? poff_s : poff_a);
  assign mode_n = valid_in ? mode : (cfg_pend ? mode_s : mode_a);

  assign restart   = resync || resync_pend;
  assign acc_b     = restart ? '0 : acc;
  assign beat_b    = restart ? '0 : beat_cnt;
  assign beat_last = (beat_b == CNT_LAST);

  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    test_sig_gen_lane #(
      .PHASE_W (PHASE_W),
      .SAMPLE_W(SAMPLE_W),
      .N_LANES (N_LANES),
      .CNT_W   (CNT_W),
      .LANE    (k)
    ) u_lane (
      .acc   (acc_b),
      .poff  (poff_n),
      .pinc  (pinc_n),
      .mode  (mode_n),
      .beat  (beat_b),
      .sample(data_n[k*SAMPLE_W +: SAMPLE_W])
    );
  end

  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      pinc_s   <= '0;
      poff_s   <= '0;
      mode_s   <= RAMP;
      cfg_pend <= 1'b0;
    end else begin
      if (valid_in) begin
        pinc_s <= pinc;
        poff_s <= poff;
        mode_s <= mode;
      end
      if (load)          cfg_pend <= 1'b0;
      else if (valid_in) cfg_pend <= 1'b1;
    end
  end

  // Output register stage (p0): beat is computed and committed only on load.
  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      pinc_a      <= '0;
      poff_a      <= '0;
      mode_a      <= RAMP;
      acc         <= '0;
      beat_cnt    <= '0;
      resync_pend <= 1'b0;
      data_p0     <= '0;
      vld_p0      <= 1'b0;
      last_p0     <= 1'b0;
    end else if (load) begin
      pinc_a      <= pinc_n;
      poff_a      <= poff_n;
      mode_a      <= mode_n;
      acc         <= acc_b + PHASE_W'(N_LANES) * pinc_n;
      beat_cnt    <= beat_last ? '0 : beat_b + CNT_W'(1);
      resync_pend <= 1'b0;
      data_p0     <= data_n;
      vld_p0      <= 1'b1;
      last_p0     <= beat_last;
    end else if (resync) begin
      resync_pend <= 1'b1;
    end
  end

  assign m_axis_tdata  = data_p0;
  assign m_axis_tvalid = vld_p0;
  assign m_axis_tlast  = last_p0;

endmodule

// File: tb/tb_test_sig_gen_mc.sv
// Directed bench for test_sig_gen_mc: default instance plus a PKT_LEN=4 instance on shared stimulus.
module tb_test_sig_gen_mc;
  import test_sig_gen_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [19:0]  pinc, poff;
  mode_t        mode;
  logic         valid_in, resync, tready;
  logic [127:0] tdata, tdata4;
  logic         tvalid, tlast, tvalid4, tlast4;

  int n_total = 0;
  int n_bad   = 0;

  localparam logic [127:0] B0 = 128'h0007_0006_0005_0004_0003_0002_0001_0000;
  localparam logic [127:0] B1 = 128'h000F_000E_000D_000C_000B_000A_0009_0008;
  localparam logic [127:0] B2 = 128'h0017_0016_0015_0014_0013_0012_0011_0010;
  localparam logic [127:0] B3 = 128'h001F_001E_001D_001C_001B_001A_0019_0018;
  localparam logic [127:0] R0 = 128'h001E_001C_001A_0018_0016_0014_0012_0010;
  localparam logic [127:0] R1 = 128'h002E_002C_002A_0028_0026_0024_0022_0020;
  localparam logic [127:0] SQ = 128'h8000_8000_8000_8000_7FFF_7FFF_7FFF_7FFF;
  localparam logic [127:0] RP = 128'hE000_C000_A000_8000_6000_4000_2000_0000;
  localparam logic [127:0] W0 = 128'hDFFF_BFFF_9FFF_7FFF_5FFF_3FFF_1FFF_0000;
  localparam logic [127:0] W1 = 128'hDFFF_BFFF_9FFF_7FFF_5FFF_3FFF_1FFF_FFFF;
  localparam logic [127:0] W2 = 128'hDFFE_BFFE_9FFE_7FFE_5FFE_3FFE_1FFE_FFFF;

  test_sig_gen_mc dut (
    .m_axis_aclk   (clk),
    .m_axis_aresetn(rst_n),
    .pinc          (pinc),
    .poff          (poff),
    .mode          (mode),
    .valid_in      (valid_in),
    .resync        (resync),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tlast  (tlast),
    .m_axis_tready (tready)
  );

  test_sig_gen_mc #(.PKT_LEN(4)) dut4 (
    .m_axis_aclk   (clk),
    .m_axis_aresetn(rst_n),
    .pinc          (pinc),
    .poff          (poff),
    .mode          (mode),
    .valid_in      (valid_in),
    .resync        (resync),
    .m_axis_tdata  (tdata4),
    .m_axis_tvalid (tvalid4),
    .m_axis_tlast  (tlast4),
    .m_axis_tready (tready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; tready = 1'b1; valid_in = 1'b0; resync = 1'b0;
    pinc = '0; poff = '0; mode = RAMP;
    repeat (2) step();
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_tvalid4", tvalid4, 0);

    rst_n = 1'b1; valid_in = 1'b1; pinc = 20'd16;
    step(); valid_in = 1'b0;
    chk("first_tvalid", tvalid, 1);
    chk("beat0", tdata, B0);
    step(); chk("beat1", tdata, B1);
    step(); chk("beat2", tdata, B2);

    tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_hold", tdata, B2);
      chk("stall_vld", tvalid, 1);
    end
    tready = 1'b1;
    step(); chk("after_stall", tdata, B3);

    tready = 1'b0;
    step(); chk("rs_hold0", tdata, B3);
    valid_in = 1'b1; resync = 1'b1; pinc = 20'd32; poff = 20'h100;
    step(); valid_in = 1'b0; resync = 1'b0;
    chk("rs_hold1", tdata, B3);
    step(); chk("rs_hold2", tdata, B3);
    tready = 1'b1;
    step(); chk("rs_beat0", tdata, R0);
    step(); chk("rs_beat1", tdata, R1);

    valid_in = 1'b1; resync = 1'b1; pinc = 20'h20000; poff = '0; mode = SQUARE;
    step(); chk("square", tdata, SQ);
    resync = 1'b0; mode = RAMP;
    step(); chk("ramp_same_phase", tdata, RP);
    resync = 1'b1; mode = COUNT;
    step(); valid_in = 1'b0; resync = 1'b0;
    chk("count_b0", tdata, B0);
    step(); chk("count_b1", tdata, B1);
    step(); chk("count_b2", tdata, B2);
    valid_in = 1'b1; mode = ZERO;
    step(); valid_in = 1'b0;
    chk("zero", tdata, 0);

    valid_in = 1'b1; resync = 1'b1; mode = RAMP; pinc = 20'h1FFFF; poff = '0;
    step(); valid_in = 1'b0; resync = 1'b0;
    chk("wrap_b0", tdata, W0);
    step(); chk("wrap_b1", tdata, W1);
    step(); chk("wrap_b2", tdata, W2);

    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_tvalid", tvalid, 0);
    chk("async_rst_tdata", tdata, 0);
    chk("async_rst_tvalid4", tvalid4, 0);

    step();
    rst_n = 1'b1; valid_in = 1'b1; pinc = 20'd16; poff = '0; mode = RAMP;
    for (int b = 0; b < 22; b++) begin
      step();
      valid_in = 1'b0;
      resync   = 1'b0;
      chk("pkt4_tlast", tlast4, (b < 18) ? (b % 4 == 3) : ((b - 18) % 4 == 3));
      if (b == 0)  chk("pkt4_b0", tdata4, B0);
      if (b == 18) chk("pkt4_resync_data", tdata4, B0);
      if (b == 17) resync = 1'b1;
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
